// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, ALU operation codes, main-control
// ALU classes and R-type funct values.
package mips_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_AW_DEFAULT = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Main-control ALU classes (loads/stores add, branches subtract, ori-style or)
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational translation of main-control aluop plus R-type funct into the
// 3-bit ALU operation code. Unknown funct values fall back to add.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_op = ALU_SUB;
      ALUOP_OR:  alu_op = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          default:   alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [1:0]        id_aluop,
  input  logic [5:0]        id_funct,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_uses_rt,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              hold,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic [DATA_W-1:0] ex_pc,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg
);

  logic [2:0]        id_alu_op;
  logic              ex_valid_reg, alusrc_reg;
  logic              mem_read_reg, mem_write_reg, reg_write_reg, mem_to_reg_reg;
  logic [2:0]        alu_op_reg;
  logic [REG_AW-1:0] rs_addr_reg, rt_addr_reg, dest_reg;
  logic [DATA_W-1:0] pc_reg, rs_data_reg, rt_data_reg, imm_reg;
  logic              load_bubble;

  alu_ctrl_decode u_alu_ctrl_decode (
    .aluop  (id_aluop),
    .funct  (id_funct),
    .alu_op (id_alu_op)
  );

  // Masked by hold so a frozen stage never races a bubble into EX.
  assign hazard_stall = ex_valid_reg & mem_read_reg & (dest_reg != '0) & id_valid & ~hold &
                        ((dest_reg == id_rs_addr) | (id_uses_rt & (dest_reg == id_rt_addr)));
  assign load_bubble  = flush | hazard_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || load_bubble) begin
      ex_valid_reg   <= 1'b0;
      pc_reg         <= '0;
      rs_addr_reg    <= '0;
      rt_addr_reg    <= '0;
      rs_data_reg    <= '0;
      rt_data_reg    <= '0;
      imm_reg        <= '0;
      alu_op_reg     <= ALU_ADD;
      alusrc_reg     <= 1'b0;
      dest_reg       <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
    end else if (!hold) begin
      ex_valid_reg   <= id_valid;
      pc_reg         <= id_pc;
      rs_addr_reg    <= id_rs_addr;
      rt_addr_reg    <= id_rt_addr;
      rs_data_reg    <= id_rs_data;
      rt_data_reg    <= id_rt_data;
      imm_reg        <= id_imm;
      alu_op_reg     <= id_alu_op;
      alusrc_reg     <= id_alusrc;
      dest_reg       <= id_regdst ? id_rd_addr : id_rt_addr;
      mem_read_reg   <= id_valid & id_mem_read;
      mem_write_reg  <= id_valid & id_mem_write;
      reg_write_reg  <= id_valid & id_reg_write;
      mem_to_reg_reg <= id_valid & id_mem_to_reg;
    end
  end

  // Source 0 is rs, source 1 is rt; EX/MEM is younger and takes priority.
  logic [REG_AW-1:0] src_addr [2];
  logic [DATA_W-1:0] src_data [2];
  logic [DATA_W-1:0] fwd_data [2];

  assign src_addr[0] = rs_addr_reg;
  assign src_addr[1] = rt_addr_reg;
  assign src_data[0] = rs_data_reg;
  assign src_data[1] = rt_data_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_data[gi] =
        (exmem_reg_write && exmem_rd != '0 && exmem_rd == src_addr[gi]) ? exmem_result :
        (memwb_reg_write && memwb_rd != '0 && memwb_rd == src_addr[gi]) ? memwb_result :
        src_data[gi];
    end
  endgenerate

  assign alu_in1       = fwd_data[0];
  assign alu_in2       = alusrc_reg ? imm_reg : fwd_data[1];
  assign ex_store_data = fwd_data[1];

  assign ex_valid      = ex_valid_reg;
  assign alu_op        = alu_op_reg;
  assign ex_dest       = dest_reg;
  assign ex_pc         = pc_reg;
  assign ex_mem_read   = mem_read_reg;
  assign ex_mem_write  = mem_write_reg;
  assign ex_reg_write  = reg_write_reg;
  assign ex_mem_to_reg = mem_to_reg_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expectations are queued as stimulus is
// driven and popped against the DUT after the edge or settle delay.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic        id_alusrc, id_regdst, id_uses_rt;
  logic        id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic        hold, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        hazard_stall, ex_valid;
  logic [2:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, ex_store_data, ex_pc;
  logic [4:0]  ex_dest;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_aluop(id_aluop), .id_funct(id_funct), .id_alusrc(id_alusrc),
    .id_regdst(id_regdst), .id_uses_rt(id_uses_rt), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .hold(hold), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_op(alu_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_pc(ex_pc), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  always #5 clk = ~clk;

  typedef enum {S_VALID, S_ALUOP, S_DEST, S_PC, S_MR, S_MW, S_RW, S_M2R,
                S_IN1, S_IN2, S_STORE, S_HAZ} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_VALID: return {31'b0, ex_valid};
      S_ALUOP: return {29'b0, alu_op};
      S_DEST:  return {27'b0, ex_dest};
      S_PC:    return ex_pc;
      S_MR:    return {31'b0, ex_mem_read};
      S_MW:    return {31'b0, ex_mem_write};
      S_RW:    return {31'b0, ex_reg_write};
      S_M2R:   return {31'b0, ex_mem_to_reg};
      S_IN1:   return alu_in1;
      S_IN2:   return alu_in2;
      S_STORE: return ex_store_data;
      S_HAZ:   return {31'b0, hazard_stall};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic expect_val(input sig_e s, input logic [31:0] v);
    exp_t e;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_all(input string step);
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s/%s observed=%h expected=%h", step, e.sig.name(), obs, e.exp);
      end
      $display("check %s/%s observed=%h expected=%h", step, e.sig.name(), obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    id_valid = 0; id_pc = '0; id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_aluop = 2'b00; id_funct = '0;
    id_alusrc = 0; id_regdst = 0; id_uses_rt = 0;
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic id_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [5:0] funct, input logic [31:0] pc);
    id_idle();
    id_valid = 1; id_pc = pc; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_aluop = 2'b10; id_funct = funct; id_regdst = 1; id_uses_rt = 1; id_reg_write = 1;
  endtask

  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
    id_idle();
    id_valid = 1; id_pc = 32'h200; id_rs_addr = rs; id_rt_addr = rt; id_imm = 32'h8;
    id_alusrc = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
  endtask

  task automatic fwd_off();
    exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
  endtask

  initial begin
    rst_n = 0; hold = 0; flush = 0;
    id_idle();
    fwd_off();
    #12;
    expect_val(S_VALID, 0); expect_val(S_ALUOP, 0); expect_val(S_RW, 0); expect_val(S_DEST, 0);
    check_all("reset");

    // Capture a sub, then reset asynchronously mid-cycle
    rst_n = 1;
    id_rtype(5'd1, 5'd2, 5'd7, 6'b100010, 32'h40);
    expect_val(S_VALID, 1); expect_val(S_ALUOP, 3'b001); expect_val(S_DEST, 7);
    tick();
    check_all("sub_capture");
    #3 rst_n = 0;
    expect_val(S_VALID, 0); expect_val(S_ALUOP, 0); expect_val(S_RW, 0); expect_val(S_DEST, 0);
    #1 check_all("async_reset");
    rst_n = 1;

    // add r3,r1,r2
    id_rtype(5'd1, 5'd2, 5'd3, 6'b100000, 32'h100);
    id_rs_data = 32'd11; id_rt_data = 32'd22;
    expect_val(S_VALID, 1); expect_val(S_ALUOP, 0); expect_val(S_DEST, 3);
    expect_val(S_RW, 1); expect_val(S_PC, 32'h100); expect_val(S_IN1, 11); expect_val(S_IN2, 22);
    tick();
    check_all("add_capture");

    // Forwarding priority on rs=5
    id_rtype(5'd5, 5'd6, 5'd8, 6'b100000, 32'h104);
    id_rs_data = 32'd10; id_rt_data = 32'd20;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'd77;
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'd99;
    expect_val(S_IN1, 77); expect_val(S_IN2, 20);
    #1 check_all("fwd_exmem");
    exmem_reg_write = 0;
    expect_val(S_IN1, 99);
    #1 check_all("fwd_memwb");
    exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    expect_val(S_IN1, 10);
    #1 check_all("fwd_r0");
    fwd_off();

    // Immediate operand with forwarded store data
    id_idle();
    id_valid = 1; id_rt_addr = 5'd9; id_rt_data = 32'd5; id_imm = 32'hFFFF_FFFC;
    id_alusrc = 1; id_mem_write = 1;
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd9; exmem_result = 32'h1234;
    memwb_reg_write = 1; memwb_rd = 5'd9; memwb_result = 32'h5555;
    expect_val(S_IN2, 32'hFFFF_FFFC); expect_val(S_STORE, 32'h1234); expect_val(S_MW, 1);
    #1 check_all("imm_store");
    fwd_off();

    // Load-use on rs
    id_lw(5'd1, 5'd4);
    expect_val(S_MR, 1); expect_val(S_DEST, 4); expect_val(S_M2R, 1);
    tick();
    check_all("lw_capture");
    id_rtype(5'd4, 5'd2, 5'd6, 6'b100000, 32'h208);
    expect_val(S_HAZ, 1);
    #1 check_all("hazard_rs");
    expect_val(S_VALID, 0); expect_val(S_MR, 0); expect_val(S_RW, 0); expect_val(S_HAZ, 0);
    tick();
    check_all("hazard_bubble");

    // Load-use on rt only, gated by id_uses_rt and hold
    id_lw(5'd1, 5'd4);
    tick();
    id_rtype(5'd1, 5'd4, 5'd6, 6'b100000, 32'h20c);
    id_uses_rt = 0;
    expect_val(S_HAZ, 0);
    #1 check_all("hazard_rt_unused");
    id_uses_rt = 1;
    expect_val(S_HAZ, 1);
    #1 check_all("hazard_rt_used");
    hold = 1;
    expect_val(S_HAZ, 0);
    #1 check_all("hazard_hold");

    // flush together with hold loads a bubble
    flush = 1;
    id_rtype(5'd1, 5'd2, 5'd12, 6'b101010, 32'h300);
    expect_val(S_VALID, 0); expect_val(S_ALUOP, 0); expect_val(S_RW, 0);
    expect_val(S_DEST, 0); expect_val(S_MR, 0);
    tick();
    check_all("flush_hold");
    flush = 0; hold = 0;

    // and r10 then hold with slt waiting in ID
    id_rtype(5'd1, 5'd2, 5'd10, 6'b100100, 32'h304);
    expect_val(S_ALUOP, 3'b010); expect_val(S_DEST, 10);
    tick();
    check_all("dec_and");
    hold = 1;
    id_rtype(5'd1, 5'd2, 5'd12, 6'b101010, 32'h308);
    for (int i = 0; i < 3; i++) begin
      expect_val(S_VALID, 1); expect_val(S_ALUOP, 3'b010); expect_val(S_DEST, 10);
      expect_val(S_PC, 32'h304);
      tick();
      check_all($sformatf("hold_%0d", i));
    end
    hold = 0;
    expect_val(S_ALUOP, 3'b100); expect_val(S_DEST, 12); expect_val(S_PC, 32'h308);
    tick();
    check_all("slt_release");

    // Decode sweep
    id_idle(); id_valid = 1; id_aluop = 2'b01;
    expect_val(S_ALUOP, 3'b001);
    tick(); check_all("dec_01");
    id_aluop = 2'b11;
    expect_val(S_ALUOP, 3'b011);
    tick(); check_all("dec_11");
    id_rtype(5'd1, 5'd2, 5'd3, 6'b100101, 32'h400);
    expect_val(S_ALUOP, 3'b011);
    tick(); check_all("dec_or");
    id_rtype(5'd1, 5'd2, 5'd3, 6'b000000, 32'h404);
    expect_val(S_ALUOP, 3'b000);
    tick(); check_all("dec_unknown");

    // Invalid capture clears control bits
    id_lw(5'd1, 5'd4);
    id_valid = 0;
    expect_val(S_VALID, 0); expect_val(S_MR, 0); expect_val(S_RW, 0); expect_val(S_M2R, 0);
    tick(); check_all("invalid_capture");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
